// File: rtl/nrzi_pkg.sv
// Shared definitions for the NRZI receive path (and the future transmitter).
package nrzi_pkg;

    typedef enum logic {
        ST_DATA  = 1'b0,
        ST_STUFF = 1'b1
    } nrzi_state_e;

    localparam logic NRZI_IDLE_LEVEL = 1'b1;

    localparam int NRZI_DATA_W_DEFAULT    = 8;
    localparam int NRZI_STUFF_LEN_DEFAULT = 6;

endpackage : nrzi_pkg

// File: rtl/nrzi_bit_decode.sv
// NRZI bit recovery: an unchanged line level decodes as 1, a level change as 0.
// Kept separate so a passive line monitor can reuse it.
module nrzi_bit_decode
    import nrzi_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic bit_en_i,
    input  logic line_i,
    output logic dec_o,
    output logic dec_valid_o
);

    logic prev_level_q;
    logic prev_level_d;

    // Track the last sampled level; a realign returns it to the idle level.
    always_comb begin
        prev_level_d = prev_level_q;
        if (clear_i) begin
            prev_level_d = NRZI_IDLE_LEVEL;
        end else if (bit_en_i) begin
            prev_level_d = line_i;
        end
    end

    // Previous-level register, idle level out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_level_q <= NRZI_IDLE_LEVEL;
        end else begin
            prev_level_q <= prev_level_d;
        end
    end

    assign dec_o       = ~(line_i ^ prev_level_q);
    assign dec_valid_o = bit_en_i;

endmodule : nrzi_bit_decode

// File: rtl/nrzi_decoder.sv
// NRZI receiver: decodes line levels, strips stuffed zeros, flags stuffing
// violations and packs kept bits LSB-first into DATA_W-bit words.
module nrzi_decoder
    import nrzi_pkg::*;
#(
    parameter int DATA_W    = NRZI_DATA_W_DEFAULT,
    parameter int STUFF_LEN = NRZI_STUFF_LEN_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              frame_start_i,
    input  logic              bit_en_i,
    input  logic              line_i,
    output logic [DATA_W-1:0] data_o,
    output logic              data_valid_o,
    output logic              stuff_err_o
);

    localparam int BIT_CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int ONES_W    = $clog2(STUFF_LEN + 1);

    localparam logic [BIT_CNT_W-1:0] LAST_BIT    = BIT_CNT_W'(DATA_W - 1);
    localparam logic [ONES_W-1:0]    STUFF_LEN_C = ONES_W'(STUFF_LEN);

    logic dec;
    logic dec_valid;
    logic strobe;
    logic run_done;

    logic [ONES_W-1:0] ones_inc;
    logic [DATA_W-1:0] shift_next;

    nrzi_state_e state_q, state_d;

    logic [ONES_W-1:0]    ones_cnt_q, ones_cnt_d;
    logic [BIT_CNT_W-1:0] bit_cnt_q,  bit_cnt_d;
    logic [DATA_W-1:0]    shift_q,    shift_d;
    logic [DATA_W-1:0]    data_q,     data_d;
    logic                 data_valid_q, data_valid_d;
    logic                 stuff_err_q,  stuff_err_d;

    nrzi_bit_decode u_bit_decode (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear_i     (frame_start_i),
        .bit_en_i    (bit_en_i),
        .line_i      (line_i),
        .dec_o       (dec),
        .dec_valid_o (dec_valid)
    );

    // A realign pulse wins over a coincident sample, so that sample is ignored.
    assign strobe     = dec_valid & ~frame_start_i;
    assign ones_inc   = ones_cnt_q + 1'b1;
    assign run_done   = dec & (ones_inc == STUFF_LEN_C);
    assign shift_next = {dec, shift_q[DATA_W-1:1]};

    // State register for the stuffing FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_DATA;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: a full run of 1s makes the following strobed bit a stuff bit.
    always_comb begin
        state_d = state_q;
        if (frame_start_i) begin
            state_d = ST_DATA;
        end else if (strobe) begin
            case (state_q)
                ST_DATA:  state_d = run_done ? ST_STUFF : ST_DATA;
                ST_STUFF: state_d = ST_DATA;
                default:  state_d = ST_DATA;
            endcase
        end
    end

    // Datapath and outputs: shift kept bits, count runs, emit word / error pulses.
    always_comb begin
        ones_cnt_d   = ones_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        data_d       = data_q;
        data_valid_d = 1'b0;
        stuff_err_d  = 1'b0;
        if (frame_start_i) begin
            ones_cnt_d = '0;
            bit_cnt_d  = '0;
            shift_d    = '0;
        end else if (strobe) begin
            if (state_q == ST_DATA) begin
                shift_d = shift_next;
                if (bit_cnt_q == LAST_BIT) begin
                    data_d       = shift_next;
                    data_valid_d = 1'b1;
                    bit_cnt_d    = '0;
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end
                if (!dec || run_done) begin
                    ones_cnt_d = '0;
                end else begin
                    ones_cnt_d = ones_inc;
                end
            end else if (dec) begin
                stuff_err_d = 1'b1;
                ones_cnt_d  = '0;
                bit_cnt_d   = '0;
                shift_d     = '0;
            end
        end
    end

    // Datapath registers; reset drops any partial word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ones_cnt_q   <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            data_q       <= '0;
            data_valid_q <= 1'b0;
            stuff_err_q  <= 1'b0;
        end else begin
            ones_cnt_q   <= ones_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            data_q       <= data_d;
            data_valid_q <= data_valid_d;
            stuff_err_q  <= stuff_err_d;
        end
    end

    assign data_o       = data_q;
    assign data_valid_o = data_valid_q;
    assign stuff_err_o  = stuff_err_q;

endmodule : nrzi_decoder

// File: tb/tb_nrzi_decoder.sv
// Self-checking bench for nrzi_decoder: directed scenarios with literal
// expectations plus randomized traffic checked every cycle against a
// queue-based behavioural model.
module tb_nrzi_decoder;

    localparam int DATA_W    = 8;
    localparam int STUFF_LEN = 6;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              frame_start_i = 1'b0;
    logic              bit_en_i = 1'b0;
    logic              line_i = 1'b1;
    logic [DATA_W-1:0] data_o;
    logic              data_valid_o;
    logic              stuff_err_o;

    int checks = 0;
    int errors = 0;
    int validSeen = 0;
    int errSeen = 0;

    // Behavioural model state
    bit          mPrev = 1'b1;
    int          mRun = 0;
    bit          mStuffPending = 1'b0;
    bit          mBits[$];
    logic [31:0] expData = '0;
    bit          expValid = 1'b0;
    bit          expErr = 1'b0;

    nrzi_decoder #(
        .DATA_W    (DATA_W),
        .STUFF_LEN (STUFF_LEN)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .frame_start_i (frame_start_i),
        .bit_en_i      (bit_en_i),
        .line_i        (line_i),
        .data_o        (data_o),
        .data_valid_o  (data_valid_o),
        .stuff_err_o   (stuff_err_o)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: decode levels, drop the bit following STUFF_LEN consecutive kept
    // 1s, collect kept bits in a queue and emit a word once DATA_W are held.
    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            mPrev = 1'b1;
            mRun = 0;
            mStuffPending = 1'b0;
            mBits.delete();
            expData = '0;
            expValid = 1'b0;
            expErr = 1'b0;
        end else begin
            expValid = 1'b0;
            expErr = 1'b0;
            if (frame_start_i) begin
                mPrev = 1'b1;
                mRun = 0;
                mStuffPending = 1'b0;
                mBits.delete();
            end else if (bit_en_i) begin
                bit d;
                d = (line_i == mPrev);
                mPrev = line_i;
                if (mStuffPending) begin
                    mStuffPending = 1'b0;
                    if (d) begin
                        expErr = 1'b1;
                        mRun = 0;
                        mBits.delete();
                    end
                end else begin
                    mBits.push_back(d);
                    mRun = d ? mRun + 1 : 0;
                    if (mRun == STUFF_LEN) begin
                        mStuffPending = 1'b1;
                        mRun = 0;
                    end
                    if (mBits.size() == DATA_W) begin
                        expData = '0;
                        for (int i = 0; i < DATA_W; i++) begin
                            if (mBits[i]) expData = expData + (32'd1 << i);
                        end
                        expValid = 1'b1;
                        mBits.delete();
                    end
                end
            end
        end
    end

    // Per-cycle comparison against the model, sampled on the falling edge.
    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            checkOutput("data_valid_o", 32'(data_valid_o), 32'(expValid));
            checkOutput("stuff_err_o", 32'(stuff_err_o), 32'(expErr));
            checkOutput("data_o", 32'(data_o), expData);
            if (data_valid_o === 1'b1) validSeen++;
            if (stuff_err_o === 1'b1) errSeen++;
        end
    end

    // Drive one cycle of inputs, changing them on the falling edge.
    task automatic applyStimulus(input logic lvl, input logic en, input logic fs);
        @(negedge clk);
        line_i = lvl;
        bit_en_i = en;
        frame_start_i = fs;
    endtask

    task automatic idleCycle();
        applyStimulus(line_i, 1'b0, 1'b0);
    endtask

    // Strobe n levels (level i taken from bit i), with optional idle gaps.
    task automatic sendLevels(input logic [15:0] levels, input int n, input int gapMax, input bit toggleIdle);
        for (int i = 0; i < n; i++) begin
            applyStimulus(levels[i], 1'b1, 1'b0);
            if (gapMax > 0) begin
                int g;
                g = 2 + int'($urandom_range(gapMax - 2));
                for (int k = 0; k < g; k++) begin
                    applyStimulus(toggleIdle ? ~line_i : line_i, 1'b0, 1'b0);
                end
            end
        end
    endtask

    // After the last strobe, check the word arrives exactly one clock later.
    task automatic expectWord(input string name, input logic [31:0] word, input int v0, input int e0);
        idleCycle();
        checkOutput({name, " valid"}, 32'(data_valid_o), 32'd1);
        checkOutput({name, " data"}, 32'(data_o), word);
        checkOutput({name, " model"}, expData, word);
        idleCycle();
        #1;
        checkOutput({name, " valid count"}, 32'(validSeen - v0), 32'd1);
        checkOutput({name, " err count"}, 32'(errSeen - e0), 32'd0);
    endtask

    localparam logic [15:0] LV_A5    = 16'h00C9;
    localparam logic [15:0] LV_FF_ST = 16'h003F;
    localparam logic [15:0] LV_ONES7 = 16'h007F;
    localparam logic [15:0] LV_3C    = 16'h00BE;

    initial begin
        int v0;
        int e0;

        repeat (3) @(negedge clk);
        checkOutput("reset data", 32'(data_o), 32'd0);
        checkOutput("reset valid", 32'(data_valid_o), 32'd0);
        checkOutput("reset err", 32'(stuff_err_o), 32'd0);
        rst_n = 1'b1;

        // Scenario 1: plain 0xA5
        applyStimulus(1'b1, 1'b0, 1'b1);
        v0 = validSeen; e0 = errSeen;
        sendLevels(LV_A5, 8, 0, 1'b0);
        expectWord("A5", 32'hA5, v0, e0);

        // Scenario 2: run of six 1s followed by a stuffed 0
        applyStimulus(1'b1, 1'b0, 1'b1);
        v0 = validSeen; e0 = errSeen;
        sendLevels(LV_FF_ST, 9, 0, 1'b0);
        expectWord("FF stuffed", 32'hFF, v0, e0);

        // Scenario 3: seven 1s is a stuffing violation, then recovery
        applyStimulus(1'b1, 1'b0, 1'b1);
        v0 = validSeen; e0 = errSeen;
        sendLevels(LV_ONES7, 7, 0, 1'b0);
        idleCycle();
        checkOutput("stuff err pulse", 32'(stuff_err_o), 32'd1);
        checkOutput("stuff err model", 32'(expErr), 32'd1);
        checkOutput("stuff err no valid", 32'(data_valid_o), 32'd0);
        idleCycle();
        #1;
        checkOutput("stuff err count", 32'(errSeen - e0), 32'd1);
        v0 = validSeen; e0 = errSeen;
        sendLevels(LV_A5, 8, 0, 1'b0);
        expectWord("A5 after err", 32'hA5, v0, e0);

        // Scenario 4: strobe gaps with a toggling line in between
        applyStimulus(1'b1, 1'b0, 1'b1);
        v0 = validSeen; e0 = errSeen;
        sendLevels(LV_A5, 8, 3, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0);
        v0 = v0 + 0;
        #1;
        checkOutput("gap data", 32'(data_o), 32'hA5);
        checkOutput("gap valid count", 32'(validSeen - v0), 32'd1);

        // Scenario 5: frame_start coincident with a strobe discards the partial word
        applyStimulus(1'b1, 1'b0, 1'b1);
        sendLevels(LV_3C, 3, 0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b1);
        v0 = validSeen; e0 = errSeen;
        sendLevels(LV_A5, 8, 0, 1'b0);
        expectWord("A5 realign", 32'hA5, v0, e0);

        // Scenario 6: reset in the middle of 0x3C
        applyStimulus(1'b1, 1'b0, 1'b1);
        sendLevels(LV_3C, 4, 0, 1'b0);
        @(negedge clk);
        bit_en_i = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        checkOutput("mid reset data", 32'(data_o), 32'd0);
        checkOutput("mid reset valid", 32'(data_valid_o), 32'd0);
        checkOutput("mid reset err", 32'(stuff_err_o), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        v0 = validSeen; e0 = errSeen;
        sendLevels(LV_3C, 8, 0, 1'b0);
        expectWord("3C after reset", 32'h3C, v0, e0);

        // Randomized traffic: long 1-runs, gaps, realigns and a mid-run reset
        for (int c = 0; c < 4000; c++) begin
            logic en;
            logic fs;
            logic lvl;
            en  = ($urandom_range(9) < 7);
            fs  = ($urandom_range(79) == 0);
            lvl = ($urandom_range(9) < 2) ? ~line_i : line_i;
            applyStimulus(lvl, en, fs);
            if (c == 2000) begin
                #2 rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
            end
        end
        idleCycle();
        idleCycle();
        #1;
        if (validSeen < 20) begin
            checkOutput("random words seen", 32'(validSeen >= 20), 32'd1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Absolute time guard so the run always terminates.
    initial begin
        #2000000;
        $display("[TB] FAIL timeout: got 0x0, expected 0x1");
        $fatal(1, "[TB] timeout");
    end

endmodule : tb_nrzi_decoder
